// File: rtl/div_if.sv
// div_if: request/response bundle between the execute stage and div_unit.
//   start, signeddiv, annul, a, b : driven by the pipeline (master)
//   stall, ready, result          : driven by the divider (slave)
interface div_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               signeddiv;
  logic               annul;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               stall;
  logic               ready;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, signeddiv, annul, a, b,
    input  stall, ready, result
  );

  modport slave (
    input  start, signeddiv, annul, a, b,
    output stall, ready, result
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV / DIVU.
//   clk  : core clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : div_if slave modport
//     start/signeddiv/a/b : launch a divide (operands sampled on the start edge)
//     annul               : cancel the in-flight divide
//     stall               : hold the front of the pipeline while busy
//     ready               : one-cycle pulse, result valid
//     result              : {HI=remainder, LO=quotient}, held until next DONE
// Latency from the start edge to ready is WIDTH+1 cycles, independent of data.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q,  state_d;
  logic               dz_q,     dz_d;      // divisor was zero
  logic               qsign_q,  qsign_d;   // negate quotient at the end
  logic               rsign_q,  rsign_d;   // negate remainder at the end
  logic [WIDTH-1:0]   a_orig_q, a_orig_d;  // raw dividend, returned in HI on /0
  logic [WIDTH-1:0]   bmag_q,   bmag_d;
  logic [WIDTH-1:0]   rem_q,    rem_d;
  logic [WIDTH-1:0]   quo_q,    quo_d;     // starts as |a|, shifts out as quotient fills in
  logic [CW-1:0]      cnt_q,    cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q,  ready_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh, trial;
  logic             step_ok;
  logic [WIDTH-1:0] rem_step, quo_step;

  // Operand magnitudes for the launch cycle.
  always_comb begin
    a_neg = bus.signeddiv & bus.a[WIDTH-1];
    b_neg = bus.signeddiv & bus.b[WIDTH-1];
    a_mag = a_neg ? -bus.a : bus.a;
    b_mag = b_neg ? -bus.b : bus.b;
  end

  // One restoring step: shift {rem, quo} left, trial-subtract at WIDTH+1 bits.
  // rem < |b| always holds, so the shifted value fits in WIDTH+1 bits and a
  // set top bit of the difference means the subtraction went negative.
  always_comb begin
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    trial    = rem_sh - {1'b0, bmag_q};
    step_ok  = ~trial[WIDTH];
    rem_step = step_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_step = {quo_q[WIDTH-2:0], step_ok};
  end

  always_comb begin
    state_d  = state_q;
    dz_d     = dz_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    a_orig_d = a_orig_q;
    bmag_d   = bmag_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ready_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.annul) begin
          dz_d     = (bus.b == '0);
          qsign_d  = bus.signeddiv & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          rsign_d  = bus.signeddiv & bus.a[WIDTH-1];
          a_orig_d = bus.a;
          bmag_d   = b_mag;
          quo_d    = a_mag;
          rem_d    = '0;
          cnt_d    = '0;
          state_d  = S_CALC;
        end
      end

      S_CALC: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 1'b1;
        if (bus.annul) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          ready_d = 1'b1;
          if (dz_q) begin
            result_d = {a_orig_q, {WIDTH{1'b1}}};
          end else begin
            // 0x80..0 / -1 needs no special case: negating 0x80..0 gives itself.
            result_d = {(rsign_q ? -rem_step : rem_step),
                        (qsign_q ? -quo_step : quo_step)};
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      dz_q     <= 1'b0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      a_orig_q <= '0;
      bmag_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dz_q     <= dz_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      a_orig_q <= a_orig_d;
      bmag_q   <= bmag_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  // stall rises in the launch cycle itself so the pipeline holds immediately.
  assign bus.stall  = (state_q == S_IDLE && bus.start && !bus.annul) ||
                      (state_q == S_CALC);
  // An annul during DONE withdraws the pulse in that same cycle.
  assign bus.ready  = ready_q & ~bus.annul;
  assign bus.result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of div_unit (WIDTH = 32).
module tb_div_unit;

    localparam int W = 32;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    logic sim_done;

    div_if #(.WIDTH(W)) bus_if ();

    div_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        sim_done = 1'b0;
        #200000;
        if (!sim_done) begin
            fails++;
            $error("FAIL timeout: bench did not finish within the wait limit");
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    // Launch at a negedge (cycle 0), check stall through CALC, ready/result at
    // cycle W+1 and that ready is gone at cycle W+2. Optionally keep start high
    // with scrambled operands during CALC to show it is ignored.
    task automatic do_div(input logic sd, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [2*W-1:0] exp_res, input string tag,
                          input logic hold_start);
        @(negedge clk);
        bus_if.signeddiv = sd;
        bus_if.a         = av;
        bus_if.b         = bv;
        bus_if.start     = 1'b1;
        #1;
        check({tag, " stall_c0"}, bus_if.stall, 1'b1);
        @(posedge clk);
        #1;
        if (!hold_start) bus_if.start = 1'b0;
        bus_if.a         = $urandom;
        bus_if.b         = $urandom;
        bus_if.signeddiv = ~sd;
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            check({tag, " stall_calc"}, bus_if.stall, 1'b1);
            check({tag, " ready_calc"}, bus_if.ready, 1'b0);
        end
        @(negedge clk);
        check({tag, " ready_done"}, bus_if.ready, 1'b1);
        check({tag, " stall_done"}, bus_if.stall, 1'b0);
        check({tag, " result"}, bus_if.result, exp_res);
        bus_if.start = 1'b0;
        @(negedge clk);
        check({tag, " ready_pulse"}, bus_if.ready, 1'b0);
        $display("[TB] %s a=%h b=%h signed=%0d result=%h expected=%h", tag, av, bv, sd,
                 bus_if.result, exp_res);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        bus_if.start     = 1'b0;
        bus_if.signeddiv = 1'b0;
        bus_if.annul     = 1'b0;
        bus_if.a         = '0;
        bus_if.b         = '0;
        rst              = 1'b1;
        repeat (2) @(negedge clk);
        check("reset ready", bus_if.ready, 1'b0);
        check("reset result", bus_if.result, 64'h0);
        check("reset stall", bus_if.stall, 1'b0);
        rst = 1'b0;

        do_div(1'b0, 32'd100,      32'd7,        {32'd2, 32'd14},              "udiv 100/7", 1'b0);
        do_div(1'b1, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, "sdiv -7/2", 1'b0);
        do_div(1'b1, 32'd7,        32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD},        "sdiv 7/-2", 1'b0);
        do_div(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14},       "sdiv -100/-7", 1'b0);
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000},        "sdiv ovf", 1'b0);
        do_div(1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h0},        "udiv 8..0/F..F", 1'b0);
        do_div(1'b0, 32'hFFFFFFFF, 32'd1,        {32'h0, 32'hFFFFFFFF},        "udiv max/1", 1'b0);
        do_div(1'b1, 32'h12345678, 32'h0,        {32'h12345678, 32'hFFFFFFFF}, "sdiv by 0", 1'b0);
        do_div(1'b0, 32'h12345678, 32'h0,        {32'h12345678, 32'hFFFFFFFF}, "udiv by 0", 1'b0);
        // start held high through CALC/DONE with garbage operands must not disturb it
        do_div(1'b0, 32'd100,      32'd7,        {32'd2, 32'd14},              "udiv hold start", 1'b1);

        // Annul at cycle 10 of CALC.
        @(negedge clk);
        bus_if.signeddiv = 1'b0;
        bus_if.a = 32'd1000;
        bus_if.b = 32'd10;
        bus_if.start = 1'b1;
        @(posedge clk);
        #1 bus_if.start = 1'b0;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        bus_if.annul = 1'b1;
        @(posedge clk);
        #1 bus_if.annul = 1'b0;
        @(negedge clk);
        check("annul stall_c11", bus_if.stall, 1'b0);
        check("annul ready_c11", bus_if.ready, 1'b0);
        check("annul result_kept", bus_if.result, {32'd2, 32'd14});
        $display("[TB] annul at cycle 10: stall=%0d ready=%0d result=%h", bus_if.stall,
                 bus_if.ready, bus_if.result);
        do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, "udiv 9/3 after annul", 1'b0);

        // Asynchronous reset at cycle 20 of CALC.
        @(negedge clk);
        bus_if.signeddiv = 1'b0;
        bus_if.a = 32'd50;
        bus_if.b = 32'd5;
        bus_if.start = 1'b1;
        @(posedge clk);
        #1 bus_if.start = 1'b0;
        for (int k = 1; k <= 20; k++) @(negedge clk);
        check("pre-rst stall", bus_if.stall, 1'b1);
        rst = 1'b1;
        #1;
        check("async rst stall", bus_if.stall, 1'b0);
        check("async rst ready", bus_if.ready, 1'b0);
        check("async rst result", bus_if.result, 64'h0);
        $display("[TB] async reset mid-CALC: stall=%0d ready=%0d result=%h", bus_if.stall,
                 bus_if.ready, bus_if.result);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            check("post-rst ready", bus_if.ready, 1'b0);
        end

        // start together with annul in IDLE launches nothing.
        @(negedge clk);
        bus_if.a = 32'd9;
        bus_if.b = 32'd3;
        bus_if.start = 1'b1;
        bus_if.annul = 1'b1;
        #1;
        check("start+annul stall", bus_if.stall, 1'b0);
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        bus_if.annul = 1'b0;
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            check("start+annul stall_idle", bus_if.stall, 1'b0);
            check("start+annul ready", bus_if.ready, 1'b0);
        end
        $display("[TB] start+annul in IDLE: stall=%0d ready=%0d", bus_if.stall, bus_if.ready);

        // The block still works after all that.
        do_div(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, "sdiv -7/2 again", 1'b0);

        sim_done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
